// File: rtl/pipeline_feeder.sv
// Feeds bots from a fixed-latency bot memory into the compute pipeline, waits for
// the pipeline to go idle, then sweeps the collector to stream every result back out.
`timescale 1ns/1ps
module pipeline_feeder #(
  parameter int ADDR_WIDTH     = 9,
  parameter int MEM_LATENCY    = 2,
  parameter int FULLNESS_LIMIT = 16,
  parameter int DRAIN_CYCLES   = 64,
  parameter int READ_LATENCY   = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] botCount,
  output logic                  busy,
  output logic                  done,
  output logic [ADDR_WIDTH-1:0] botMemAddr,
  input  logic [127:0]          botMemData,
  input  logic [5:0]            botMemPermut,
  output logic [127:0]          bot,
  output logic [ADDR_WIDTH-1:0] botIndex,
  output logic                  isBotValid,
  output logic [5:0]            validBotPermutations,
  input  logic [4:0]            fifoFullness,
  input  logic [37:0]           summedDataOut,
  input  logic [2:0]            pcoeffCountIn,
  output logic                  resultValid,
  output logic [ADDR_WIDTH-1:0] resultIndex,
  output logic [37:0]           resultSum,
  output logic [2:0]            resultPcoeffCount,
  output logic [2:0]            dbg_state
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_FEED    = 3'd1,
    S_DRAIN   = 3'd2,
    S_READOUT = 3'd3,
    S_FLUSH   = 3'd4
  } state_t;

  localparam int CW = ADDR_WIDTH + 1;
  localparam int IW = $clog2(DRAIN_CYCLES + 1);
  localparam logic [CW-1:0] CNT_ONE   = CW'(1);
  localparam logic [IW-1:0] IDLE_ONE  = IW'(1);
  localparam logic [IW-1:0] IDLE_LAST = IW'(DRAIN_CYCLES - 1);
  localparam logic [5:0]    FULL_LIM  = 6'(FULLNESS_LIMIT);

  state_t          state_q, state_d;
  logic [CW-1:0]   n_q, n_d;
  logic [CW-1:0]   issue_cnt_q, issue_cnt_d;
  logic [CW-1:0]   ret_cnt_q, ret_cnt_d;
  logic [CW-1:0]   rd_cnt_q, rd_cnt_d;
  logic [IW-1:0]   idle_cnt_q, idle_cnt_d;

  logic [MEM_LATENCY-1:0]  mem_vld_q;
  logic [ADDR_WIDTH-1:0]   mem_tag_q [MEM_LATENCY];
  logic [READ_LATENCY-1:0] rd_vld_q;
  logic [ADDR_WIDTH-1:0]   rd_tag_q  [READ_LATENCY];

  logic [127:0]          bot_q;
  logic [5:0]            perm_q;
  logic [ADDR_WIDTH-1:0] bot_index_q;
  logic [ADDR_WIDTH-1:0] res_index_q;
  logic [37:0]           res_sum_q;
  logic [2:0]            res_pc_q;

  logic issue;
  logic mem_ret;
  logic rd_issue;
  logic rd_ret;

  // isBotValid and resultValid are single-cycle strobes with no ready: the pipeline
  // always accepts, and the only throttle is fifoFullness gating new memory reads.
  assign issue    = (state_q == S_FEED) && (issue_cnt_q < n_q) &&
                    ({1'b0, fifoFullness} < FULL_LIM);
  assign mem_ret  = mem_vld_q[MEM_LATENCY-1];
  assign rd_issue = (state_q == S_READOUT);
  assign rd_ret   = rd_vld_q[READ_LATENCY-1];

  assign botMemAddr = issue_cnt_q[ADDR_WIDTH-1:0];
  assign busy       = (state_q != S_IDLE);
  assign done       = (state_q == S_FLUSH) && (rd_vld_q == '0);
  assign dbg_state  = state_q;

  always_comb begin
    isBotValid           = mem_ret;
    bot                  = bot_q;
    validBotPermutations = perm_q;
    botIndex             = bot_index_q;
    resultValid          = rd_ret;
    resultIndex          = res_index_q;
    resultSum            = res_sum_q;
    resultPcoeffCount    = res_pc_q;
    if (mem_ret) begin
      bot                  = botMemData;
      validBotPermutations = botMemPermut;
      botIndex             = mem_tag_q[MEM_LATENCY-1];
    end else if (rd_issue) begin
      botIndex = rd_cnt_q[ADDR_WIDTH-1:0];
    end
    if (rd_ret) begin
      resultIndex       = rd_tag_q[READ_LATENCY-1];
      resultSum         = summedDataOut;
      resultPcoeffCount = pcoeffCountIn;
    end
  end

  always_comb begin
    state_d     = state_q;
    n_d         = n_q;
    issue_cnt_d = issue_cnt_q;
    ret_cnt_d   = ret_cnt_q;
    rd_cnt_d    = rd_cnt_q;
    idle_cnt_d  = idle_cnt_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          n_d         = {1'b0, botCount};
          issue_cnt_d = '0;
          ret_cnt_d   = '0;
          idle_cnt_d  = '0;
          state_d     = (botCount == '0) ? S_FLUSH : S_FEED;
        end
      end
      S_FEED: begin
        if (issue) issue_cnt_d = issue_cnt_q + CNT_ONE;
        if (mem_ret) begin
          ret_cnt_d = ret_cnt_q + CNT_ONE;
          if (ret_cnt_q + CNT_ONE == n_q) state_d = S_DRAIN;
        end
      end
      S_DRAIN: begin
        // Any nonzero fullness restarts the idle window from scratch.
        if (fifoFullness != '0) begin
          idle_cnt_d = '0;
        end else if (idle_cnt_q == IDLE_LAST) begin
          idle_cnt_d = idle_cnt_q + IDLE_ONE;
          rd_cnt_d   = '0;
          state_d    = S_READOUT;
        end else begin
          idle_cnt_d = idle_cnt_q + IDLE_ONE;
        end
      end
      S_READOUT: begin
        rd_cnt_d = rd_cnt_q + CNT_ONE;
        if (rd_cnt_q + CNT_ONE == n_q) state_d = S_FLUSH;
      end
      S_FLUSH: begin
        if (rd_vld_q == '0) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= S_IDLE;
      n_q         <= '0;
      issue_cnt_q <= '0;
      ret_cnt_q   <= '0;
      rd_cnt_q    <= '0;
      idle_cnt_q  <= '0;
      bot_q       <= '0;
      perm_q      <= '0;
      bot_index_q <= '0;
      res_index_q <= '0;
      res_sum_q   <= '0;
      res_pc_q    <= '0;
    end else begin
      state_q     <= state_d;
      n_q         <= n_d;
      issue_cnt_q <= issue_cnt_d;
      ret_cnt_q   <= ret_cnt_d;
      rd_cnt_q    <= rd_cnt_d;
      idle_cnt_q  <= idle_cnt_d;
      bot_q       <= bot;
      perm_q      <= validBotPermutations;
      bot_index_q <= botIndex;
      res_index_q <= resultIndex;
      res_sum_q   <= resultSum;
      res_pc_q    <= resultPcoeffCount;
    end
  end

  // Tag pipes run in lock-step with the memory and collector read latencies.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mem_vld_q <= '0;
      rd_vld_q  <= '0;
      for (int i = 0; i < MEM_LATENCY; i++) mem_tag_q[i] <= '0;
      for (int i = 0; i < READ_LATENCY; i++) rd_tag_q[i] <= '0;
    end else begin
      mem_vld_q[0] <= issue;
      mem_tag_q[0] <= issue_cnt_q[ADDR_WIDTH-1:0];
      for (int i = 1; i < MEM_LATENCY; i++) begin
        mem_vld_q[i] <= mem_vld_q[i-1];
        mem_tag_q[i] <= mem_tag_q[i-1];
      end
      rd_vld_q[0] <= rd_issue;
      rd_tag_q[0] <= rd_cnt_q[ADDR_WIDTH-1:0];
      for (int i = 1; i < READ_LATENCY; i++) begin
        rd_vld_q[i] <= rd_vld_q[i-1];
        rd_tag_q[i] <= rd_tag_q[i-1];
      end
    end
  end

endmodule

// File: tb/tb_pipeline_feeder.sv
// Directed bench for pipeline_feeder: cycle-exact feed, drain, readout and done timing
// against a behavioural bot memory and result collector.
`timescale 1ns/1ps
module tb_pipeline_feeder;
  localparam int AW = 9;
  localparam int ML = 2;
  localparam int RL = 2;

  // clock / reset
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic          start;
  logic [AW-1:0] botCount;
  logic          busy, done;
  logic [AW-1:0] botMemAddr;
  logic [127:0]  botMemData;
  logic [5:0]    botMemPermut;
  logic [127:0]  bot;
  logic [AW-1:0] botIndex;
  logic          isBotValid;
  logic [5:0]    validBotPermutations;
  logic [4:0]    fifoFullness;
  logic [37:0]   summedDataOut;
  logic [2:0]    pcoeffCountIn;
  logic          resultValid;
  logic [AW-1:0] resultIndex;
  logic [37:0]   resultSum;
  logic [2:0]    resultPcoeffCount;
  logic [2:0]    dbg_state;

  pipeline_feeder dut (
    .clk(clk), .rst(rst), .start(start), .botCount(botCount),
    .busy(busy), .done(done), .botMemAddr(botMemAddr),
    .botMemData(botMemData), .botMemPermut(botMemPermut),
    .bot(bot), .botIndex(botIndex), .isBotValid(isBotValid),
    .validBotPermutations(validBotPermutations), .fifoFullness(fifoFullness),
    .summedDataOut(summedDataOut), .pcoeffCountIn(pcoeffCountIn),
    .resultValid(resultValid), .resultIndex(resultIndex), .resultSum(resultSum),
    .resultPcoeffCount(resultPcoeffCount), .dbg_state(dbg_state)
  );

  bit perm_all;

  function automatic logic [127:0] bot_word(input int a);
    return {32'hB0B0_0000, 32'(a) * 32'd3, 32'h0, 32'(a)};
  endfunction
  function automatic logic [5:0] exp_perm(input int a);
    return perm_all ? 6'h3F : (6'(a) ^ 6'h01);
  endfunction
  function automatic logic [37:0] sum_word(input int a);
    return 38'h20_0000_0000 + 38'(a) * 38'd1000 + 38'd5;
  endfunction
  function automatic logic [2:0] pc_word(input int a);
    return 3'(a + 3);
  endfunction

  // bot memory and result collector models, both fixed-latency from their address
  logic [AW-1:0] mem_a [ML];
  logic [AW-1:0] col_a [RL];
  always @(posedge clk) begin
    mem_a[0] <= botMemAddr;
    for (int i = 1; i < ML; i++) mem_a[i] <= mem_a[i-1];
    col_a[0] <= botIndex;
    for (int i = 1; i < RL; i++) col_a[i] <= col_a[i-1];
  end
  assign botMemData    = bot_word(int'(mem_a[ML-1]));
  assign botMemPermut  = exp_perm(int'(mem_a[ML-1]));
  assign summedDataOut = sum_word(int'(col_a[RL-1]));
  assign pcoeffCountIn = pc_word(int'(col_a[RL-1]));

  // scoreboard logs
  int n_vec;
  int n_miss;
  int           fed_idx[$];
  logic [127:0] fed_bot[$];
  logic [5:0]   fed_perm[$];
  int           fed_cyc[$];
  int           res_idx[$];
  logic [37:0]  res_sum[$];
  logic [2:0]   res_pc[$];
  int           res_cyc[$];
  int           done_cyc[$];
  int           busy_cnt;
  int           ff_plan[512];
  int           inj_start_cyc;
  bit           timed_out;

  task automatic clear_log();
    fed_idx.delete(); fed_bot.delete(); fed_perm.delete(); fed_cyc.delete();
    res_idx.delete(); res_sum.delete(); res_pc.delete(); res_cyc.delete();
    done_cyc.delete();
    busy_cnt = 0; inj_start_cyc = 0; timed_out = 0;
    for (int i = 0; i < 512; i++) ff_plan[i] = 0;
  endtask

  // driver: start is seen at the edge that ends cycle 0; returns at the cycle-1 sample point
  task automatic do_start(input int n);
    @(negedge clk);
    start = 1'b1; botCount = AW'(n); fifoFullness = 5'd0;
    @(negedge clk);
    start = 1'b0;
  endtask

  // monitor: logs outputs each cycle; inputs set at cycle c apply to the edge ending cycle c
  task automatic collect(input int budget);
    int c;
    bit fin;
    c = 1; fin = 0;
    while (!fin) begin
      if (isBotValid === 1'b1) begin
        fed_idx.push_back(int'(botIndex)); fed_bot.push_back(bot);
        fed_perm.push_back(validBotPermutations); fed_cyc.push_back(c);
      end
      if (resultValid === 1'b1) begin
        res_idx.push_back(int'(resultIndex)); res_sum.push_back(resultSum);
        res_pc.push_back(resultPcoeffCount); res_cyc.push_back(c);
      end
      if (done === 1'b1) done_cyc.push_back(c);
      if (busy === 1'b1) busy_cnt++;
      start        = (c == inj_start_cyc);
      botCount     = AW'(5);
      fifoFullness = (c < 512) ? 5'(ff_plan[c]) : 5'd0;
      if (done_cyc.size() > 0 && c >= done_cyc[0] + 3) fin = 1;
      else if (c >= budget) begin timed_out = 1; fin = 1; end
      else begin c++; @(negedge clk); end
    end
    start = 1'b0; fifoFullness = 5'd0;
  endtask

  task automatic test_reset();
    #2;
    n_vec++;
    if ({busy, done, isBotValid, resultValid} !== 4'b0) begin
      n_miss++; $display("FAIL reset_ctrl got=%b exp=0000", {busy, done, isBotValid, resultValid});
    end
    n_vec++;
    if ({botIndex, botMemAddr, resultIndex} !== '0) begin
      n_miss++; $display("FAIL reset_addr got=%0h exp=0", {botIndex, botMemAddr, resultIndex});
    end
    n_vec++;
    if (dbg_state !== 3'd0) begin
      n_miss++; $display("FAIL reset_state got=%0d exp=0", dbg_state);
    end
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_basic_n4();
    perm_all = 1; clear_log();
    do_start(4);
    collect(300);
    n_vec++;
    if (timed_out !== 1'b0) begin n_miss++; $display("FAIL basic_timeout got=1 exp=0"); end
    n_vec++;
    if (fed_idx.size() != 4) begin n_miss++; $display("FAIL basic_fed_count got=%0d exp=4", fed_idx.size()); end
    for (int i = 0; i < fed_idx.size() && i < 4; i++) begin
      n_vec++;
      if (fed_idx[i] != i || fed_cyc[i] != 3 + i) begin
        n_miss++; $display("FAIL basic_fed_%0d got idx=%0d cyc=%0d exp idx=%0d cyc=%0d", i, fed_idx[i], fed_cyc[i], i, 3 + i);
      end
      n_vec++;
      if (fed_bot[i] !== bot_word(i) || fed_perm[i] !== 6'h3F) begin
        n_miss++; $display("FAIL basic_bot_%0d got=%h/%h exp=%h/3f", i, fed_bot[i], fed_perm[i], bot_word(i));
      end
    end
    n_vec++;
    if (res_idx.size() != 4) begin n_miss++; $display("FAIL basic_res_count got=%0d exp=4", res_idx.size()); end
    for (int i = 0; i < res_idx.size() && i < 4; i++) begin
      n_vec++;
      if (res_idx[i] != i || res_cyc[i] != 73 + i || res_sum[i] !== sum_word(i) || res_pc[i] !== pc_word(i)) begin
        n_miss++; $display("FAIL basic_res_%0d got idx=%0d cyc=%0d sum=%h pc=%0d exp idx=%0d cyc=%0d sum=%h pc=%0d",
          i, res_idx[i], res_cyc[i], res_sum[i], res_pc[i], i, 73 + i, sum_word(i), pc_word(i));
      end
    end
    n_vec++;
    if (done_cyc.size() != 1 || done_cyc[0] != 77) begin
      n_miss++; $display("FAIL basic_done got n=%0d first=%0d exp n=1 cyc=77", done_cyc.size(), (done_cyc.size() > 0) ? done_cyc[0] : -1);
    end
    n_vec++;
    if (busy_cnt != 77) begin n_miss++; $display("FAIL basic_busy_cycles got=%0d exp=77", busy_cnt); end
  endtask

  task automatic test_reset_mid_feed();
    perm_all = 0; clear_log();
    do_start(10);
    repeat (3) @(negedge clk);
    n_vec++;
    if (botMemAddr !== AW'(3) || isBotValid !== 1'b1 || botIndex !== AW'(1)) begin
      n_miss++; $display("FAIL midfeed_pre got addr=%0d vld=%b idx=%0d exp addr=3 vld=1 idx=1", botMemAddr, isBotValid, botIndex);
    end
    rst = 1'b0;
    #1;
    n_vec++;
    if ({busy, done, isBotValid, resultValid} !== 4'b0) begin
      n_miss++; $display("FAIL midfeed_ctrl got=%b exp=0000", {busy, done, isBotValid, resultValid});
    end
    n_vec++;
    if ({botIndex, botMemAddr, resultIndex} !== '0) begin
      n_miss++; $display("FAIL midfeed_addr got=%0h exp=0", {botIndex, botMemAddr, resultIndex});
    end
    n_vec++;
    if ({bot, validBotPermutations} !== '0) begin
      n_miss++; $display("FAIL midfeed_bot got=%h exp=0", {bot, validBotPermutations});
    end
    n_vec++;
    if ({resultSum, resultPcoeffCount} !== '0) begin
      n_miss++; $display("FAIL midfeed_result got=%h exp=0", {resultSum, resultPcoeffCount});
    end
    @(negedge clk); rst = 1'b1;
    @(negedge clk);
    clear_log();
    do_start(2);
    collect(300);
    n_vec++;
    if (fed_idx.size() != 2 || res_idx.size() != 2 || timed_out) begin
      n_miss++; $display("FAIL rerun_counts got fed=%0d res=%0d to=%0d exp 2 2 0", fed_idx.size(), res_idx.size(), timed_out);
    end
    for (int i = 0; i < fed_idx.size() && i < 2; i++) begin
      n_vec++;
      if (fed_idx[i] != i || fed_cyc[i] != 3 + i || fed_perm[i] !== exp_perm(i)) begin
        n_miss++; $display("FAIL rerun_fed_%0d got idx=%0d cyc=%0d perm=%h exp %0d %0d %h", i, fed_idx[i], fed_cyc[i], fed_perm[i], i, 3 + i, exp_perm(i));
      end
    end
    for (int i = 0; i < res_idx.size() && i < 2; i++) begin
      n_vec++;
      if (res_idx[i] != i || res_sum[i] !== sum_word(i)) begin
        n_miss++; $display("FAIL rerun_res_%0d got idx=%0d sum=%h exp %0d %h", i, res_idx[i], res_sum[i], i, sum_word(i));
      end
    end
    n_vec++;
    if (done_cyc.size() != 1 || done_cyc[0] != 73) begin
      n_miss++; $display("FAIL rerun_done got n=%0d exp n=1 cyc=73", done_cyc.size());
    end
  endtask

  task automatic test_stall();
    int exp_cyc[6];
    exp_cyc = '{3, 24, 25, 26, 27, 28};
    perm_all = 0; clear_log();
    for (int k = 2; k <= 21; k++) ff_plan[k] = 16;
    do_start(6);
    collect(400);
    n_vec++;
    if (fed_idx.size() != 6) begin n_miss++; $display("FAIL stall_fed_count got=%0d exp=6", fed_idx.size()); end
    for (int i = 0; i < fed_idx.size() && i < 6; i++) begin
      n_vec++;
      if (fed_idx[i] != i || fed_cyc[i] != exp_cyc[i] || fed_bot[i] !== bot_word(i)) begin
        n_miss++; $display("FAIL stall_fed_%0d got idx=%0d cyc=%0d exp idx=%0d cyc=%0d", i, fed_idx[i], fed_cyc[i], i, exp_cyc[i]);
      end
    end
    n_vec++;
    if (res_idx.size() != 6 || done_cyc.size() != 1 || done_cyc[0] != 101) begin
      n_miss++; $display("FAIL stall_tail got res=%0d done_n=%0d exp res=6 done at 101", res_idx.size(), done_cyc.size());
    end
  endtask

  task automatic test_n0();
    clear_log();
    do_start(0);
    collect(40);
    n_vec++;
    if (done_cyc.size() != 1 || done_cyc[0] != 1) begin
      n_miss++; $display("FAIL n0_done got n=%0d first=%0d exp n=1 cyc=1", done_cyc.size(), (done_cyc.size() > 0) ? done_cyc[0] : -1);
    end
    n_vec++;
    if (busy_cnt != 1) begin n_miss++; $display("FAIL n0_busy_cycles got=%0d exp=1", busy_cnt); end
    n_vec++;
    if (fed_idx.size() != 0 || res_idx.size() != 0) begin
      n_miss++; $display("FAIL n0_traffic got fed=%0d res=%0d exp 0 0", fed_idx.size(), res_idx.size());
    end
  endtask

  task automatic test_drain_restart();
    perm_all = 1; clear_log();
    ff_plan[44] = 3;
    do_start(1);
    collect(400);
    n_vec++;
    if (res_cyc.size() != 1 || res_cyc[0] != 111 || res_sum[0] !== sum_word(0)) begin
      n_miss++; $display("FAIL drain_restart_res got n=%0d cyc=%0d exp n=1 cyc=111", res_cyc.size(), (res_cyc.size() > 0) ? res_cyc[0] : -1);
    end
    n_vec++;
    if (done_cyc.size() != 1 || done_cyc[0] != 112) begin
      n_miss++; $display("FAIL drain_restart_done got n=%0d exp n=1 cyc=112", done_cyc.size());
    end
  endtask

  task automatic test_start_during_readout();
    perm_all = 0; clear_log();
    inj_start_cyc = 71;
    do_start(3);
    collect(400);
    n_vec++;
    if (res_idx.size() != 3 || fed_idx.size() != 3) begin
      n_miss++; $display("FAIL restart_ignored_counts got res=%0d fed=%0d exp 3 3", res_idx.size(), fed_idx.size());
    end
    for (int i = 0; i < res_idx.size() && i < 3; i++) begin
      n_vec++;
      if (res_idx[i] != i || res_cyc[i] != 72 + i || res_pc[i] !== pc_word(i)) begin
        n_miss++; $display("FAIL restart_res_%0d got idx=%0d cyc=%0d exp idx=%0d cyc=%0d", i, res_idx[i], res_cyc[i], i, 72 + i);
      end
    end
    n_vec++;
    if (done_cyc.size() != 1 || done_cyc[0] != 75 || busy_cnt != 75) begin
      n_miss++; $display("FAIL restart_done got n=%0d busy=%0d exp n=1 cyc=75 busy=75", done_cyc.size(), busy_cnt);
    end
  endtask

  initial begin
    n_vec = 0; n_miss = 0;
    rst = 1'b0; start = 1'b0; botCount = '0; fifoFullness = 5'd0; perm_all = 1;
    clear_log();
    test_reset();
    test_basic_n4();
    test_reset_mid_feed();
    test_stall();
    test_n0();
    test_drain_restart();
    test_start_during_readout();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule

// File: doc/pipeline_feeder.md
Name: pipeline_feeder

Overview:
Drives the input side of the full compute pipeline and drains its result side. Per job, it streams botCount bots with their permutation-valid masks from a fixed-latency bot memory into the pipeline, throttled by the pipeline's lagging fifoFullness. It waits for the pipeline to go idle, then sweeps the shared botIndex/readAddr bus to read every accumulated sum and pcoeff count back out as a result stream.

Parameters:
ADDR_WIDTH, 9, width of botIndex/readAddr and of botCount.
MEM_LATENCY, 2, cycles from botMemAddr to valid botMemData/botMemPermut; must be ≥1.
FULLNESS_LIMIT, 16, stop issuing when fifoFullness ≥ this value; sized for fullness lag plus MEM_LATENCY in-flight reads.
DRAIN_CYCLES, 64, consecutive cycles with fifoFullness==0 before the pipeline counts as idle; must be ≥1.
READ_LATENCY, 2, cycles from botIndex to valid summedDataOut/pcoeffCountOut; must be ≥1.

Ports:
clk  in  1  clock
rst  in  1  asynchronous, active-low reset
start  in  1  single-cycle job start; ignored unless busy==0
botCount  in  ADDR_WIDTH  number of bots in the job, sampled on start; 0 is legal
busy  out  1  high from the cycle after an accepted start until done
done  out  1  one-cycle pulse when the job finishes
botMemAddr  out  ADDR_WIDTH  bot memory read address
botMemData  in  128  bot word, MEM_LATENCY after address
botMemPermut  in  6  permutation mask {ABC,ACB,BAC,BCA,CAB,CBA}, same timing as botMemData
bot  out  128  to pipeline bot
botIndex  out  ADDR_WIDTH  to pipeline botIndex (also collector read address)
isBotValid  out  1  to pipeline isBotValid
validBotPermutations  out  6  to pipeline validBotPermutations
fifoFullness  in  5  from pipeline
summedDataOut  in  38  from pipeline
pcoeffCountIn  in  3  from pipeline pcoeffCountOut
resultValid  out  1  result strobe
resultIndex  out  ADDR_WIDTH  bot index of result
resultSum  out  38  captured summedDataOut
resultPcoeffCount  out  3  captured pcoeffCountIn

Behaviour:
- Reset (rst=0, asynchronous): state IDLE. All outputs 0: busy, done, isBotValid, resultValid, botIndex, botMemAddr, bot, validBotPermutations, resultIndex, resultSum, resultPcoeffCount. All counters and the valid delay line are 0. Any in-flight job is discarded. There is no partial result and no done pulse.
- FSM states: IDLE, FEED, DRAIN, READOUT, FLUSH.
- IDLE: start=1 latches botCount as N and clears the issue counter, return counter, and idle counter.
  - N==0: go to FLUSH with an empty pipe. This gives done one cycle later with no results.
  - Otherwise go to FEED.
- FEED, issue side: issue = (issueCnt<N) && (fifoFullness<FULLNESS_LIMIT).
  - On issue: botMemAddr=issueCnt, then issueCnt++.
  - A MEM_LATENCY-deep shift register carries {valid, addr} alongside the read.
- FEED, return side: the cycle data returns, drive bot=botMemData, validBotPermutations=botMemPermut, botIndex=addr, isBotValid=1, and increment returnCnt.
  - Bots with an all-zero mask are still forwarded; the pipeline filters them.
  - In-flight reads are never dropped by a stall.
- Leaving FEED: when returnCnt==N after an increment, go to DRAIN.
- Outside return cycles, isBotValid=0. bot and validBotPermutations hold their last values. botIndex stays under FSM control.
- DRAIN: isBotValid=0. idleCnt increments while fifoFullness==0 and resets to 0 on any nonzero value. When idleCnt reaches DRAIN_CYCLES, clear the read counter and go to READOUT.
- READOUT: drive botIndex=rdCnt, then rdCnt++, for rdCnt 0..N-1, one per cycle with no stalls.
  - A READ_LATENCY-deep shift register tags {valid, index}.
  - When a tag emerges: resultValid=1, resultIndex=tag, resultSum=summedDataOut, resultPcoeffCount=pcoeffCountIn.
  - After the last address is issued, go to FLUSH.
- FLUSH: wait until the tag shift register is empty, then pulse done=1 for one cycle, set busy=0, and go to IDLE.
  - done is the cycle after the last resultValid, or the cycle after start when N==0.
- Throughput: FEED with no backpressure takes N+MEM_LATENCY cycles.
- Ordering: results emerge in index order 0..N-1, exactly N results per job. Result data is only meaningful in resultValid cycles.
- start while busy=1 is ignored.
- Counters are ADDR_WIDTH+1 bits, so N up to 2^ADDR_WIDTH-1 causes no wrap-around.
- fifoFullness rising to the limit in the same cycle as the final issue does not affect that issue: issue is evaluated with registered inputs of that cycle.

Test Plan:
- Reset mid-FEED (N=10, assert rst=0 after 3 issues) -> all outputs 0 immediately; a subsequent start with N=2 runs cleanly with indices 0,1.
- N=4, fifoFullness=0, memory returns bot=i and permut=6'h3F -> isBotValid high for cycles MEM_LATENCY+1..MEM_LATENCY+4 (counted from the start cycle) with botIndex 0,1,2,3; DRAIN after 64 idle cycles; readout gives 4 results with resultSum=model[i]; done one cycle after the last result.
- fifoFullness held at 16 from the 2nd issue for 20 cycles (N=6) -> exactly 1 issue before the stall, the already in-flight read is still forwarded, remaining issues resume after release; isBotValid asserts exactly 6 times total.
- N=0 -> busy high for one cycle, no isBotValid, no resultValid, done pulse one cycle after start.
- During DRAIN, fifoFullness pulses to 3 at idleCnt=40 -> idleCnt restarts; READOUT begins only after 64 further consecutive zero cycles.
- start asserted again during READOUT -> ignored; result count stays N and done pulses once.
